timer_32: RTL and testbench

- Free-running 32-bit cycle counter with a fixed-period tick generator, used by the signal-acquisition top level and its benches.
- Provides a global timebase (`count`), a one-cycle wrap pulse (`pulse_full`) and a one-cycle 10 ms tick (`pulse_10ms`).
- Consumers use `count` bit-slices for periodic stimulus and housekeeping windows.

---
 rtl/timer_32.sv | 95 +++++++++
 tb/tb_timer_32.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_32.sv
// ---------------------------------------------------------------------------
// timer_32 -- free-running 32-bit cycle counter with a fixed-period tick.
//
// Provides the global timebase for the acquisition top level:
//   count      : registered cycle count, advances on every enabled cycle and
//                wraps modulo 2^32.
//   pulse_full : one-cycle pulse, high exactly in the cycle count reads 0
//                after wrapping from 0xFFFFFFFF.
//   pulse_10ms : one-cycle pulse every DIV_10MS enabled cycles, generated by
//                a prescaler that is independent of the count bits.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active low
//   clr        in   1   synchronous clear of counter and prescaler
//   ena        in   1   count enable
//   count      out  32  current cycle count
//   pulse_full out  1   wrap pulse
//   pulse_10ms out  1   10 ms tick pulse
//
// Priority on each edge: reset > clr > ena > hold. Both pulses are forced
// low whenever the counter is not advancing, so they never stretch.
// ---------------------------------------------------------------------------
module timer_32 #(
    parameter int unsigned DIV_10MS = 1111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        ena,
    output logic [31:0] count,
    output logic        pulse_full,
    output logic        pulse_10ms
);

    // A divider below 2 would make the prescaler degenerate; the width is
    // clamped to 1 bit so elaboration still succeeds after the error report.
    localparam int PW = (DIV_10MS < 2) ? 1 : $clog2(DIV_10MS);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV_10MS - 1);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    if (DIV_10MS < 2) begin : g_bad_div
        $error("timer_32: DIV_10MS must be at least 2");
    end

    logic [31:0]   count_q,      count_d;
    logic [PW-1:0] prescaler_q,  prescaler_d;
    logic          pulse_full_q, pulse_full_d;
    logic          pulse_10ms_q, pulse_10ms_d;

    // Next-state logic. Pulses default low so a paused or cleared cycle
    // always drops them; the wrap pulse is raised on the edge that takes
    // the count from all-ones to zero, so it is visible while count reads 0.
    always_comb begin
        count_d      = count_q;
        prescaler_d  = prescaler_q;
        pulse_full_d = 1'b0;
        pulse_10ms_d = 1'b0;

        if (clr) begin
            count_d     = 32'd0;
            prescaler_d = '0;
        end else if (ena) begin
            count_d      = count_q + 32'd1;
            pulse_full_d = (count_q == 32'hFFFF_FFFF);
            if (prescaler_q == PS_LAST) begin
                prescaler_d  = '0;
                pulse_10ms_d = 1'b1;
            end else begin
                prescaler_d  = prescaler_q + PS_ONE;
            end
        end
    end

    // State registers with synchronous active-low reset; reset wins over
    // clr and ena and emits no pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q      <= 32'd0;
            prescaler_q  <= '0;
            pulse_full_q <= 1'b0;
            pulse_10ms_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            prescaler_q  <= prescaler_d;
            pulse_full_q <= pulse_full_d;
            pulse_10ms_q <= pulse_10ms_d;
        end
    end

    assign count      = count_q;
    assign pulse_full = pulse_full_q;
    assign pulse_10ms = pulse_10ms_q;

endmodule

// File: tb/tb_timer_32.sv
// ---------------------------------------------------------------------------
// tb_timer_32 -- directed bench for timer_32.
// Two instances share the stimulus: dut10 (DIV_10MS=10) covers reset,
// enable/pause, clear, tick spacing and wrap; dut4 (DIV_10MS=4) covers a
// wrap coinciding with a tick. Near-wrap counts are deposited by briefly
// forcing the count register while the counter is paused.
// ---------------------------------------------------------------------------
module tb_timer_32;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ena;
    logic [31:0] count10;
    logic        pf10;
    logic        pt10;
    logic [31:0] count4;
    logic        pf4;
    logic        pt4;

    int n_checks;
    int n_pass;

    timer_32 #(.DIV_10MS(10)) dut10 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .ena        (ena),
        .count      (count10),
        .pulse_full (pf10),
        .pulse_10ms (pt10)
    );

    timer_32 #(.DIV_10MS(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .ena        (ena),
        .count      (count4),
        .pulse_full (pf4),
        .pulse_10ms (pt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs are changed and outputs sampled
    // 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        ena = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clr = 1'b0;
        ena = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            n_checks++;
            if ({count10, pf10, pt10} !== 34'd0)
                $display("[TB] FAIL reset_hold cyc %0d: got count=%0h pf=%b pt=%b expected 0/0/0",
                         k, count10, pf10, pt10);
            else
                n_pass++;
        end
        rst = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            n_checks++;
            if (count10 !== 32'(k))
                $display("[TB] FAIL reset_release_count edge %0d: got %0d expected %0d", k, count10, k);
            else
                n_pass++;
            n_checks++;
            if (pt10 !== ((k % 10) == 0))
                $display("[TB] FAIL tick_period edge %0d: got %b expected %b", k, pt10, (k % 10) == 0);
            else
                n_pass++;
            n_checks++;
            if (pf10 !== 1'b0)
                $display("[TB] FAIL no_wrap edge %0d: got %b expected 0", k, pf10);
            else
                n_pass++;
        end
    endtask

    task automatic test_enable_pause();
        do_reset();
        ena = 1'b1;
        repeat (50) step();
        n_checks++;
        if (count10 !== 32'd50)
            $display("[TB] FAIL run50: got %0d expected 50", count10);
        else
            n_pass++;
        ena = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if ({count10, pf10, pt10} !== {32'd50, 1'b0, 1'b0})
                $display("[TB] FAIL paused cyc %0d: got count=%0d pf=%b pt=%b expected 50/0/0",
                         k, count10, pf10, pt10);
            else
                n_pass++;
        end
        ena = 1'b1;
        repeat (30) step();
        n_checks++;
        if (count10 !== 32'd80)
            $display("[TB] FAIL resume80: got %0d expected 80", count10);
        else
            n_pass++;
        n_checks++;
        if (pt10 !== 1'b1)
            $display("[TB] FAIL tick_at80: got %b expected 1", pt10);
        else
            n_pass++;
    endtask

    task automatic test_tick_pause();
        do_reset();
        ena = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            n_checks++;
            if (pt10 !== (k == 10))
                $display("[TB] FAIL tick_pre edge %0d: got %b expected %b", k, pt10, k == 10);
            else
                n_pass++;
        end
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({count10, pt10} !== {32'd15, 1'b0})
                $display("[TB] FAIL tick_paused cyc %0d: got count=%0d pt=%b expected 15/0", k, count10, pt10);
            else
                n_pass++;
        end
        ena = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            step();
            n_checks++;
            if ({count10, pt10} !== {32'(15 + j), ((15 + j) % 10) == 0})
                $display("[TB] FAIL tick_delayed edge %0d: got count=%0d pt=%b expected %0d/%b",
                         j, count10, pt10, 15 + j, ((15 + j) % 10) == 0);
            else
                n_pass++;
        end
    endtask

    task automatic test_clear();
        do_reset();
        ena = 1'b1;
        repeat (500) step();
        n_checks++;
        if ({count10, pt10} !== {32'd500, 1'b1})
            $display("[TB] FAIL pre_clear: got count=%0d pt=%b expected 500/1", count10, pt10);
        else
            n_pass++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if ({count10, pf10, pt10} !== 34'd0)
            $display("[TB] FAIL clear: got count=%0d pf=%b pt=%b expected 0/0/0", count10, pf10, pt10);
        else
            n_pass++;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if ({count10, pt10} !== {32'(k), k == 10})
                $display("[TB] FAIL post_clear edge %0d: got count=%0d pt=%b expected %0d/%b",
                         k, count10, pt10, k, k == 10);
            else
                n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        logic        exp_pf  [4];
        exp_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        exp_pf  = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        force dut10.count_q = 32'hFFFF_FFFD;
        #1;
        release dut10.count_q;
        n_checks++;
        if (count10 !== 32'hFFFF_FFFD)
            $display("[TB] FAIL wrap_deposit: got %0h expected fffffffd", count10);
        else
            n_pass++;
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({count10, pf10} !== {exp_seq[k], exp_pf[k]})
                $display("[TB] FAIL wrap_seq %0d: got count=%0h pf=%b expected %0h/%b",
                         k, count10, pf10, exp_seq[k], exp_pf[k]);
            else
                n_pass++;
        end
        ena = 1'b0;
        force dut10.count_q = 32'hFFFF_FFFF;
        #1;
        release dut10.count_q;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({count10, pf10} !== {32'hFFFF_FFFF, 1'b0})
                $display("[TB] FAIL wrap_paused %0d: got count=%0h pf=%b expected ffffffff/0", k, count10, pf10);
            else
                n_pass++;
        end
        ena = 1'b1;
        step();
        n_checks++;
        if ({count10, pf10} !== {32'h0, 1'b1})
            $display("[TB] FAIL wrap_resume: got count=%0h pf=%b expected 0/1", count10, pf10);
        else
            n_pass++;
        step();
        n_checks++;
        if ({count10, pf10} !== {32'h1, 1'b0})
            $display("[TB] FAIL wrap_one_cycle: got count=%0h pf=%b expected 1/0", count10, pf10);
        else
            n_pass++;
    endtask

    task automatic test_coincident();
        logic [31:0] exp_seq [4];
        do_reset();
        force dut4.count_q = 32'hFFFF_FFFC;
        #1;
        release dut4.count_q;
        ena = 1'b1;
        exp_seq = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({count4, pf4, pt4} !== {exp_seq[k], k == 3, k == 3})
                $display("[TB] FAIL coincide %0d: got count=%0h pf=%b pt=%b expected %0h/%b/%b",
                         k, count4, pf4, pt4, exp_seq[k], k == 3, k == 3);
            else
                n_pass++;
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({count4, pf4, pt4} !== 34'd0)
            $display("[TB] FAIL coincide_reset: got count=%0h pf=%b pt=%b expected 0/0/0", count4, pf4, pt4);
        else
            n_pass++;
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if ({count4, pf4, pt4} !== {32'(k), 1'b0, k == 4})
                $display("[TB] FAIL div4_restart edge %0d: got count=%0d pf=%b pt=%b expected %0d/0/%b",
                         k, count4, pf4, pt4, k, k == 4);
            else
                n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        clr = 1'b0;
        ena = 1'b0;
        test_reset();
        test_enable_pause();
        test_tick_pause();
        test_clear();
        test_wrap();
        test_coincident();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
